// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle RV32 subset sequencer: opcode fields,
// FSM states, datapath select codes and the instruction-class enum.
package seq_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_ADD     = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_BRANCH = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_S  = 2'b01;
    localparam logic [1:0] IMM_B  = 2'b10;
    localparam logic [1:0] IMM_J  = 2'b11;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        CL_R    = 3'd0,
        CL_ADDI = 3'd1,
        CL_LW   = 3'd2,
        CL_SW   = 3'd3,
        CL_BR   = 3'd4,
        CL_JAL  = 3'd5,
        CL_ILL  = 3'd6
    } iclass_e;

    typedef struct packed {
        logic       alu_add;
        logic       asel;
        logic       bsel;
        logic [1:0] immsel;
    } alu_ctl_t;

    // ALU operand/operation selects set up in EXEC and held through MEM/WB.
    function automatic alu_ctl_t class_alu_ctl(input iclass_e cls, input logic is_sub);
        alu_ctl_t ctl;
        ctl = '{alu_add: 1'b0, asel: 1'b0, bsel: 1'b0, immsel: IMM_I};
        case (cls)
            CL_R:    ctl.alu_add = !is_sub;
            CL_ADDI: begin
                ctl.alu_add = 1'b1;
                ctl.bsel    = 1'b1;
            end
            CL_LW:   begin
                ctl.alu_add = 1'b1;
                ctl.bsel    = 1'b1;
            end
            CL_SW:   begin
                ctl.alu_add = 1'b1;
                ctl.bsel    = 1'b1;
                ctl.immsel  = IMM_S;
            end
            CL_JAL:  begin
                ctl.alu_add = 1'b1;
                ctl.asel    = 1'b1;
                ctl.bsel    = 1'b1;
                ctl.immsel  = IMM_J;
            end
            default: ctl.alu_add = 1'b0;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction classifier: maps opcode/funct3/funct7 of the
// instruction register onto an instruction class, flagging anything undecodable.
module seq_decode
    import seq_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output iclass_e    o_class,
    output logic       o_illegal,
    output logic       o_sub,
    output logic       o_bne
);

    always_comb begin
        o_class = CL_ILL;
        case (i_opcode)
            OPC_OP: begin
                if (i_funct7 == F7_ADD || i_funct7 == F7_SUB) begin
                    o_class = CL_R;
                end
            end
            OPC_OP_IMM: begin
                if (i_funct3 == F3_ADDI) begin
                    o_class = CL_ADDI;
                end
            end
            OPC_LOAD: begin
                if (i_funct3 == F3_WORD) begin
                    o_class = CL_LW;
                end
            end
            OPC_STORE: begin
                if (i_funct3 == F3_WORD) begin
                    o_class = CL_SW;
                end
            end
            OPC_BRANCH: begin
                if (i_funct3 == F3_BEQ || i_funct3 == F3_BNE) begin
                    o_class = CL_BR;
                end
            end
            OPC_JAL: o_class = CL_JAL;
            default: o_class = CL_ILL;
        endcase
    end

    assign o_illegal = (o_class == CL_ILL);
    assign o_sub     = (i_funct7 == F7_SUB);
    assign o_bne     = (i_funct3 == F3_BNE);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32 add/sub/addi/lw/sw/beq/bne/jal datapath.
// Define SEQ_PERF_EN to build the cycle/retire performance counters.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             rf_we,
    output logic             alu_add,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       immsel,
    output logic [1:0]       wbsel,
    output logic [2:0]       state_o,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    state_e   r_state;
    state_e   w_state_next;
    logic     r_taken;
    iclass_e  w_class;
    logic     w_illegal;
    logic     w_sub;
    logic     w_bne;
    alu_ctl_t w_alu;

    // Register specifiers belong to the datapath; the sequencer never looks at them.
    logic w_unused_reg_fields;
    assign w_unused_reg_fields = ^{instr[24:15], instr[11:7]};

    seq_decode u_decode (
        .i_opcode  (instr[6:0]),
        .i_funct3  (instr[14:12]),
        .i_funct7  (instr[31:25]),
        .o_class   (w_class),
        .o_illegal (w_illegal),
        .o_sub     (w_sub),
        .o_bne     (w_bne)
    );

    assign w_alu = class_alu_ctl(w_class, w_sub);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Branch outcome is captured while the ALU compares rs1/rs2, so BRANCH
    // can reuse the ALU for the PC+imm target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken <= 1'b0;
        end else if (r_state == ST_EXEC && w_class == CL_BR) begin
            r_taken <= zero ^ w_bne;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (mem_ack) begin
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = w_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (w_class)
                    CL_R, CL_ADDI, CL_JAL: w_state_next = ST_WB;
                    CL_LW, CL_SW:          w_state_next = ST_MEM;
                    CL_BR:                 w_state_next = ST_BRANCH;
                    default:               w_state_next = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    w_state_next = (w_class == CL_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_BRANCH: w_state_next = ST_FETCH;
            ST_WB:     w_state_next = ST_FETCH;
            ST_TRAP:   w_state_next = ST_TRAP;
            default:   w_state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        rf_we        = 1'b0;
        alu_add      = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        immsel       = IMM_I;
        wbsel        = WB_ALU;
        illegal      = 1'b0;
        retire       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // Reset parks the FSM here, so the request is held off until rst_n releases.
                mem_req = rst_n;
                ir_load = rst_n & mem_ack;
            end
            ST_EXEC: begin
                alu_add = w_alu.alu_add;
                asel    = w_alu.asel;
                bsel    = w_alu.bsel;
                immsel  = w_alu.immsel;
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_class == CL_SW);
                alu_add      = w_alu.alu_add;
                asel         = w_alu.asel;
                bsel         = w_alu.bsel;
                immsel       = w_alu.immsel;
                if (mem_ack && w_class == CL_SW) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            ST_BRANCH: begin
                asel    = 1'b1;
                bsel    = 1'b1;
                immsel  = IMM_B;
                alu_add = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = r_taken;
                retire  = 1'b1;
            end
            ST_WB: begin
                alu_add = w_alu.alu_add;
                asel    = w_alu.asel;
                bsel    = w_alu.bsel;
                immsel  = w_alu.immsel;
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                case (w_class)
                    CL_LW:   wbsel = WB_MEM;
                    CL_JAL:  wbsel = WB_PC4;
                    default: wbsel = WB_ALU;
                endcase
                pc_sel  = (w_class == CL_JAL);
            end
            ST_TRAP: illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    assign state_o = r_state;

`ifdef SEQ_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a table of instructions with
// memory wait states plus hand-written trap and reset-abort sequences.
module tb_multicycle_sequencer;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [31:0]      instr;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_load;
    logic             pc_we;
    logic             pc_sel;
    logic             rf_we;
    logic             alu_add;
    logic             asel;
    logic             bsel;
    logic [1:0]       immsel;
    logic [1:0]       wbsel;
    logic [2:0]       state_o;
    logic             illegal;
    logic             retire;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .zero         (zero),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_load      (ir_load),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .alu_add      (alu_add),
        .asel         (asel),
        .bsel         (bsel),
        .immsel       (immsel),
        .wbsel        (wbsel),
        .state_o      (state_o),
        .illegal      (illegal),
        .retire       (retire),
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot at the retire cycle: {pc_we,pc_sel,rf_we,mem_we,asel,bsel,alu_add,immsel,wbsel}
    typedef struct {
        string       name;
        logic [31:0] word;
        int          fw;
        int          mw;
        logic        z;
        int          cyc;
        int          reqs;
        logic [10:0] snap;
    } vec_t;

    int          n_vec;
    int          n_bad;
    int          t_cycles;
    int          t_retires;
    int          t_reqs;
    logic [10:0] t_snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Memory acks after fw (fetch) or mw (data) wait cycles; IR loads on ir_load.
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic z);
        int req_run;
        bit load;
        bit done;
        t_cycles  = 0;
        t_retires = 0;
        t_reqs    = 0;
        t_snap    = '0;
        req_run   = 0;
        done      = 0;
        while (!done && t_cycles < 60) begin
            @(negedge clk);
            zero    = z;
            mem_ack = mem_req && (req_run >= (mem_addr_sel ? mw : fw));
            #1;
            t_cycles++;
            load = ir_load;
            if (mem_req) t_reqs++;
            if (mem_req && !mem_ack) req_run++;
            else req_run = 0;
            if (retire) begin
                t_retires++;
                t_snap = {pc_we, pc_sel, rf_we, mem_we, asel, bsel, alu_add, immsel, wbsel};
                done = 1;
            end
            @(posedge clk);
            #1;
            if (load) instr = w;
            mem_ack = 1'b0;
        end
    endtask

    vec_t vecs[13];
    int   sum_cyc;
    int   bad_cycles;
    bit   retire_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"addi",     32'h00500093, 0, 0, 1'b0,  4, 1, 11'b1_0_1_0_0_1_1_00_01};
        vecs[1]  = '{"add",      32'h002081B3, 0, 0, 1'b0,  4, 1, 11'b1_0_1_0_0_0_1_00_01};
        vecs[2]  = '{"sub",      32'h402081B3, 0, 0, 1'b0,  4, 1, 11'b1_0_1_0_0_0_0_00_01};
        vecs[3]  = '{"lw",       32'h0080A283, 0, 0, 1'b0,  5, 2, 11'b1_0_1_0_0_1_1_00_00};
        vecs[4]  = '{"lw_wait",  32'h0080A283, 3, 3, 1'b0, 11, 8, 11'b1_0_1_0_0_1_1_00_00};
        vecs[5]  = '{"sw",       32'h0020A623, 0, 0, 1'b0,  4, 2, 11'b1_0_0_1_0_1_1_01_01};
        vecs[6]  = '{"sw_wait",  32'h0020A623, 1, 2, 1'b0,  7, 5, 11'b1_0_0_1_0_1_1_01_01};
        vecs[7]  = '{"beq_tk",   32'h00208463, 0, 0, 1'b1,  4, 1, 11'b1_1_0_0_1_1_1_10_01};
        vecs[8]  = '{"beq_nt",   32'h00208463, 0, 0, 1'b0,  4, 1, 11'b1_0_0_0_1_1_1_10_01};
        vecs[9]  = '{"bne_tk",   32'h00209463, 0, 0, 1'b0,  4, 1, 11'b1_1_0_0_1_1_1_10_01};
        vecs[10] = '{"bne_nt",   32'h00209463, 0, 0, 1'b1,  4, 1, 11'b1_0_0_0_1_1_1_10_01};
        vecs[11] = '{"jal",      32'h010000EF, 0, 0, 1'b0,  4, 1, 11'b1_1_1_0_1_1_1_11_10};
        vecs[12] = '{"addi_fw2", 32'h00500093, 2, 0, 1'b0,  6, 3, 11'b1_0_1_0_0_1_1_00_01};

        n_vec   = 0;
        n_bad   = 0;
        sum_cyc = 0;
        rst_n   = 1'b0;
        instr   = 32'h0;
        zero    = 1'b0;
        mem_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", state_o, 3'd0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_flags", {illegal, retire, pc_we, rf_we, ir_load}, 5'b0);
        chk("rst_counters", {cycle_cnt, retire_cnt}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_mem_req", mem_req, 1'b1);

        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i].word, vecs[i].fw, vecs[i].mw, vecs[i].z);
            sum_cyc += vecs[i].cyc;
            chk({vecs[i].name, "_cycles"}, t_cycles, vecs[i].cyc);
            chk({vecs[i].name, "_retires"}, t_retires, 1);
            chk({vecs[i].name, "_req_cycles"}, t_reqs, vecs[i].reqs);
            chk({vecs[i].name, "_retire_ctl"}, t_snap, vecs[i].snap);
            chk({vecs[i].name, "_back_to_fetch"}, state_o, 3'd0);
        end

`ifdef SEQ_PERF_EN
        chk("perf_retire_cnt", retire_cnt, 13);
        chk("perf_cycle_cnt", cycle_cnt, sum_cyc);
`else
        chk("perf_tied_off", {cycle_cnt, retire_cnt}, 64'h0);
`endif

        // Illegal opcode: FETCH -> DECODE -> TRAP, sticky until reset
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        chk("ill_fetch_irload", ir_load, 1'b1);
        @(posedge clk);
        #1;
        instr   = 32'h0000007F;
        mem_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("ill_decode_state", state_o, 3'd1);
        @(negedge clk);
        #1;
        chk("ill_trap_state", state_o, 3'd6);
        chk("ill_flag", illegal, 1'b1);
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ack = i[0];
            zero    = i[1];
            #1;
            if ({mem_req, mem_we, ir_load, pc_we, rf_we, retire} != 6'b0 || !illegal || state_o != 3'd6)
                bad_cycles++;
        end
        chk("ill_trap_hold_bad_cycles", bad_cycles, 0);
        #1;
        rst_n   = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("ill_rst_state", state_o, 3'd0);
        chk("ill_rst_flag", illegal, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset asserted in the middle of sw's data phase
        retire_seen = 0;
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        retire_seen |= retire;
        @(posedge clk);
        #1;
        instr   = 32'h0020A623;
        mem_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            retire_seen |= retire;
        end
        @(negedge clk);
        #1;
        retire_seen |= retire;
        chk("sw_mem_phase", {state_o, mem_req, mem_we}, {3'd3, 2'b11});
        #1;
        rst_n = 1'b0;
        #1;
        retire_seen |= retire;
        chk("sw_abort_drop", {mem_req, mem_we}, 2'b00);
        chk("sw_abort_state", state_o, 3'd0);
        chk("sw_abort_no_retire", retire_seen, 1'b0);
        chk("sw_abort_counters", {cycle_cnt, retire_cnt}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(32'h00500093, 0, 0, 1'b0);
        chk("recover_addi_cycles", t_cycles, 4);
        chk("recover_addi_ctl", t_snap, 11'b1_0_1_0_0_1_1_00_01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32 subset datapath: add, sub, addi, lw, sw, beq, bne and jal. It replaces single-cycle control with a per-instruction state machine. Instruction fetch and data access share one memory port through a req/ack handshake. It drives the existing datapath select encodings, and issues PC, IR and register-file write strobes one state at a time.

## Interface
- CNT_W, 32: width of the performance counters.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  current instruction register contents.
- zero  in  1  ALU result-equals-zero flag.
- mem_ack  in  1  memory port completion; sampled only while mem_req=1.
- mem_req  out  1  memory access request; held until ack.
- mem_we  out  1  1 = write (sw data phase), 0 = read.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data).
- ir_load  out  1  load instr register from memory read data.
- pc_we  out  1  PC write strobe.
- pc_sel  out  1  0 = PC+4, 1 = ALU result.
- rf_we  out  1  register-file write strobe.
- alu_add  out  1  1 = add, 0 = sub.
- asel  out  1  0 = rs1 data, 1 = PC.
- bsel  out  1  0 = rs2 data, 1 = immediate.
- immsel  out  2  I = 00, S = 01, B = 10, J = 11.
- wbsel  out  2  00 = memory data, 01 = ALU, 10 = PC+4.
- state_o  out  3  current state encoding.
- illegal  out  1  sticky; set on an undecodable instruction.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- cycle_cnt  out  CNT_W  cycles since reset (see Configuration).
- retire_cnt  out  CNT_W  instructions retired since reset.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, BRANCH=4, WB=5, TRAP=6.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0, mem_we=0.
  - ir_load=mem_ack.
  - Stays in FETCH until mem_ack, then goes to DECODE.
- DECODE:
  - Classifies opcode/funct3/funct7.
  - Legal encodings:
    - 0110011 with funct7 0000000 is add; with 0100000 is sub.
    - 0010011 with funct3 000 is addi.
    - 0000011 with funct3 010 is lw; 0100011 with funct3 010 is sw.
    - 1100011 with funct3 000 is beq; with 001 is bne.
    - 1101111 is jal.
  - Anything else goes to TRAP.
- EXEC, by instruction class:
  - R-type: asel=0, bsel=0, alu_add per funct7; next state WB.
  - addi: bsel=1, immsel=00, alu_add=1; next state WB.
  - lw/sw: bsel=1, immsel=00 (lw) or 01 (sw), alu_add=1; next state MEM.
  - beq/bne: asel=0, bsel=0, alu_add=0; zero registered into taken_q (inverted for bne); next state BRANCH.
  - jal: asel=1, bsel=1, immsel=11, alu_add=1; next state WB.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we=1 for sw; ALU controls held from EXEC.
  - On mem_ack: lw goes to WB. sw does pc_we=1, pc_sel=0, retire, then FETCH.
- BRANCH:
  - Outputs: asel=1, bsel=1, immsel=10, alu_add=1, pc_we=1, pc_sel=taken_q.
  - retire, then FETCH.
- WB:
  - Outputs: rf_we=1, pc_we=1, retire.
  - wbsel is 01 for ALU ops, 00 for lw, 10 for jal.
  - pc_sel=1 for jal (ALU still computing PC+imm), else 0.
  - Next state FETCH.
- TRAP: all strobes 0, illegal=1; held until reset.
- Outputs not listed for a state are 0; immsel=00 and wbsel=01 when unused.
- Writes to rd=x0 are issued normally; the register file discards them.

## Timing
- Reset (async, rst_n=0):
  - State goes to FETCH immediately.
  - Every strobe (mem_req excepted), illegal, retire and taken_q go to 0; counters go to 0.
  - mem_req is 0 while rst_n=0 and asserts in the first cycle after deassertion.
  - An in-flight memory access is abandoned; the memory must tolerate req dropping.
- Outputs are decoded combinationally from the registered state, registered IR and taken_q; there is no glitch requirement.
- mem_ack may be high in the same cycle mem_req rises (zero-wait memory). Wait states extend FETCH/MEM indefinitely.
- mem_ack while mem_req=0 is ignored.
- Zero-wait latency in cycles:
  - add/sub/addi/jal = 4.
  - lw = 5.
  - sw = 4.
  - beq/bne = 4.
- retire coincides with the cycle in which pc_we=1. Exactly one retire per instruction; none in TRAP.
- Counters wrap modulo 2^CNT_W.

## Configuration
- SEQ_PERF_EN defined: cycle_cnt increments every cycle outside reset; retire_cnt increments on retire.
- SEQ_PERF_EN undefined: cycle_cnt and retire_cnt tie to 0 and no counter flops are built. The port list is unchanged.

## Structure
- Package seq_pkg holds:
  - opcode, funct3 and funct7 constants;
  - the state enum;
  - the immsel and wbsel encodings;
  - the instruction-class enum (R, ADDI, LW, SW, BR, JAL, ILL).
- Sub-module seq_decode: combinational classifier from instr to class and illegal, used in DECODE and for output decoding.

## Test plan
- addi x1,x0,5 with zero-wait memory:
  - Exactly 4 cycles from FETCH back to FETCH.
  - WB has rf_we=1, wbsel=01, bsel=1, immsel=00.
  - One retire pulse.
- lw with mem_ack delayed 3 cycles in both FETCH and MEM:
  - mem_req is held the whole time; total 11 cycles.
  - WB has wbsel=00.
- beq with zero=1, then beq with zero=0:
  - Branch-state pc_sel is 1 for the first and 0 for the second.
  - Branch-state immsel is 10.
  - Branch-state pc_we is 1 in both.
- jal:
  - WB has wbsel=10, pc_sel=1, rf_we=1, asel=1, immsel=11.
- Illegal opcode 0x0000007F:
  - TRAP in the cycle after DECODE; illegal=1 and strobes 0 for 20 cycles.
  - rst_n pulse returns the sequencer to FETCH with illegal=0.
- rst_n low mid-MEM of sw:
  - mem_req and mem_we drop without waiting for a clock edge.
  - No retire; with SEQ_PERF_EN, both counters read 0 afterwards.
